// File: rtl/player_ctrl_pkg.sv
// Shared definitions for the player controller slice.
//   state_t     : game FSM encoding (IDLE=0, PLAY=1, FLIGHT=2, OVER=3)
//   SEL_*       : bit positions inside the 5-bit select bus from controls
//   *_W, *_MAX  : field widths and saturation limits of the game counters
package player_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_FLIGHT = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  localparam int SEL_MOVE       = 4;
  localparam int SEL_AIM        = 3;
  localparam int SEL_NEW_REQ    = 2;
  localparam int SEL_NEW_COMMIT = 1;

  localparam int AIM_W    = 3;
  localparam int SHOT_Y_W = 4;
  localparam int CNT_W    = 4;

  localparam logic [CNT_W-1:0] SCORE_MAX = 4'd15;

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   d     : level input
//   rise  : high for the one cycle in which d is seen high after being seen
//           low on the previous clock edge
// The detector arms itself on the first clock after reset, so a level that
// is already high when reset is released is not taken as an edge; it must
// fall and rise again.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic armed;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= 1'b0;
      armed <= 1'b0;
    end else begin
      d_q   <= d;
      armed <= 1'b1;
    end
  end

  assign rise = armed & d & ~d_q;

endmodule

// File: rtl/player_ctrl.sv
// Player game-state controller: consumes command pulses from the controls
// front end and keeps position, aim, projectile flight, score and shot count.
//   clk, reset      : clock, asynchronous active-low reset
//   left_x/right_x  : move pulses (honoured in PLAY/FLIGHT with select[4])
//   left_aim/right_aim : aim pulses (honoured in PLAY with select[3])
//   shoot_out       : fire pulse (PLAY only, needs shots_left > 0)
//   select[4:0]     : command class; rising edge of select[1] starts a game
//   frame_tick      : advances the projectile
//   hit             : projectile struck the target (FLIGHT only)
//   player_x, aim   : current position / aim
//   shot_*          : flight state latched at fire, shot_y = progress
//   fire            : one-cycle launch pulse
//   score, shots_left, game_over, state : game bookkeeping
// Every output is a flop; inputs only reach outputs through a clock edge.
module player_ctrl
  import player_ctrl_pkg::*;
#(
  parameter int X_W      = 5,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 31,
  parameter int X_INIT   = 15,
  parameter int AIM_MAX  = 7,
  parameter int AIM_INIT = 4,
  parameter int SHOT_LEN = 12,
  parameter int SHOTS    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left_x,
  input  logic             right_x,
  input  logic             left_aim,
  input  logic             right_aim,
  input  logic             shoot_out,
  input  logic [4:0]       select,
  input  logic             frame_tick,
  input  logic             hit,
  output logic [X_W-1:0]   player_x,
  output logic [AIM_W-1:0] aim,
  output logic             shot_active,
  output logic [X_W-1:0]   shot_x,
  output logic [AIM_W-1:0] shot_aim,
  output logic [SHOT_Y_W-1:0] shot_y,
  output logic             fire,
  output logic [CNT_W-1:0] score,
  output logic [CNT_W-1:0] shots_left,
  output logic             game_over,
  output logic [1:0]       state
);

  state_t state_q, state_d;

  logic [X_W-1:0]      x_d, shot_x_d;
  logic [AIM_W-1:0]    aim_d, shot_aim_d;
  logic [SHOT_Y_W-1:0] shot_y_d;
  logic [CNT_W-1:0]    score_d, shots_left_d;
  logic                active_d, fire_d;

  logic commit;
  logic can_move;
  logic last_tick;

  // select[2] is informational and select[0] is unassigned.
  logic unused_sel;
  assign unused_sel = select[SEL_NEW_REQ] ^ select[0];

  edge_rise u_commit (
    .clk   (clk),
    .rst_n (reset),
    .d     (select[SEL_NEW_COMMIT]),
    .rise  (commit)
  );

  assign can_move  = ((state_q == ST_PLAY) || (state_q == ST_FLIGHT)) && select[SEL_MOVE];
  assign last_tick = frame_tick && (shot_y == SHOT_Y_W'(SHOT_LEN - 1));

  // NOTE: every variable written here gets its hold value first, so no path
  // through the branches leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    x_d          = player_x;
    aim_d        = aim;
    shot_x_d     = shot_x;
    shot_aim_d   = shot_aim;
    shot_y_d     = shot_y;
    active_d     = shot_active;
    score_d      = score;
    shots_left_d = shots_left;
    fire_d       = 1'b0;

    if (commit) begin
      // A new game overrides anything else that happens this cycle.
      state_d      = ST_PLAY;
      x_d          = X_W'(X_INIT);
      aim_d        = AIM_W'(AIM_INIT);
      shot_x_d     = '0;
      shot_aim_d   = '0;
      shot_y_d     = '0;
      active_d     = 1'b0;
      score_d      = '0;
      shots_left_d = CNT_W'(SHOTS);
    end else begin
      if (can_move) begin
        if (left_x && !right_x && (player_x != X_W'(X_MIN)))
          x_d = player_x - 1'b1;
        else if (right_x && !left_x && (player_x != X_W'(X_MAX)))
          x_d = player_x + 1'b1;
      end

      case (state_q)
        ST_PLAY: begin
          if (select[SEL_AIM]) begin
            if (left_aim && !right_aim && (aim != '0))
              aim_d = aim - 1'b1;
            else if (right_aim && !left_aim && (aim != AIM_W'(AIM_MAX)))
              aim_d = aim + 1'b1;
          end
          if (shoot_out && (shots_left != '0)) begin
            fire_d       = 1'b1;
            state_d      = ST_FLIGHT;
            shot_x_d     = player_x;
            shot_aim_d   = aim;
            shot_y_d     = '0;
            active_d     = 1'b1;
            shots_left_d = shots_left - 1'b1;
          end
        end
        ST_FLIGHT: begin
          // shot_y stops at its last value; the final tick ends the flight.
          if (frame_tick && !last_tick)
            shot_y_d = shot_y + 1'b1;
          if (hit || last_tick) begin
            active_d = 1'b0;
            state_d  = (shots_left != '0) ? ST_PLAY : ST_OVER;
            if (hit && (score != SCORE_MAX))
              score_d = score + 1'b1;
          end
        end
        default: ;  // IDLE and OVER wait for the new-game commit
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      player_x    <= X_W'(X_INIT);
      aim         <= AIM_W'(AIM_INIT);
      shot_x      <= '0;
      shot_aim    <= '0;
      shot_y      <= '0;
      shot_active <= 1'b0;
      fire        <= 1'b0;
      score       <= '0;
      shots_left  <= CNT_W'(SHOTS);
      game_over   <= 1'b0;
    end else begin
      state_q     <= state_d;
      player_x    <= x_d;
      aim         <= aim_d;
      shot_x      <= shot_x_d;
      shot_aim    <= shot_aim_d;
      shot_y      <= shot_y_d;
      shot_active <= active_d;
      fire        <= fire_d;
      score       <= score_d;
      shots_left  <= shots_left_d;
      game_over   <= (state_d == ST_OVER);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: directed game scenarios followed by a
// randomized command stream, all compared cycle by cycle with a reference
// model of the game rules held in plain integers.
module tb_player_ctrl;

  localparam int P_IDLE = 0, P_PLAY = 1, P_FLIGHT = 2, P_OVER = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       left_x = 0, right_x = 0, left_aim = 0, right_aim = 0, shoot_out = 0;
  logic [4:0] select = '0;
  logic       frame_tick = 0, hit = 0;
  logic [4:0] player_x, shot_x;
  logic [2:0] aim, shot_aim;
  logic [3:0] shot_y, score, shots_left;
  logic       shot_active, fire, game_over;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  logic s1 = 1'b0;  // level held on select[1] for all directed steps

  // reference model
  int m_state, m_x, m_aim, m_act, m_sx, m_saim, m_sy, m_fire, m_score, m_left;
  int m_prev, m_prev_valid;

  player_ctrl dut (
    .clk(clk), .reset(reset),
    .left_x(left_x), .right_x(right_x), .left_aim(left_aim), .right_aim(right_aim),
    .shoot_out(shoot_out), .select(select), .frame_tick(frame_tick), .hit(hit),
    .player_x(player_x), .aim(aim), .shot_active(shot_active), .shot_x(shot_x),
    .shot_aim(shot_aim), .shot_y(shot_y), .fire(fire), .score(score),
    .shots_left(shots_left), .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_new_game(input int st);
    m_state = st; m_x = 15; m_aim = 4; m_act = 0; m_sx = 0; m_saim = 0;
    m_sy = 0; m_fire = 0; m_score = 0; m_left = 5;
  endtask

  task automatic model_reset();
    model_new_game(P_IDLE);
    m_prev = 0; m_prev_valid = 0;
  endtask

  // One clock of the game rules, given the inputs sampled at that edge.
  task automatic model_step(input logic lx, rx, la, ra, sh, input logic [4:0] sel,
                            input logic ft, h);
    int  old_x = m_x, old_aim = m_aim;
    bit  commit = m_prev_valid && sel[1] && !m_prev;
    bit  ended;
    m_prev_valid = 1; m_prev = sel[1];
    m_fire = 0;
    if (commit) begin
      model_new_game(P_PLAY);
      return;
    end
    if ((m_state == P_PLAY || m_state == P_FLIGHT) && sel[4])
      m_x = clamp(m_x + int'(rx) - int'(lx), 0, 31);
    if (m_state == P_PLAY) begin
      if (sel[3]) m_aim = clamp(m_aim + int'(ra) - int'(la), 0, 7);
      if (sh && m_left > 0) begin
        m_fire = 1; m_sx = old_x; m_saim = old_aim; m_sy = 0; m_act = 1;
        m_left--; m_state = P_FLIGHT;
      end
    end else if (m_state == P_FLIGHT) begin
      ended = h || (ft && m_sy == 11);
      if (ft && m_sy < 11) m_sy++;
      if (h) m_score = (m_score < 15) ? m_score + 1 : 15;
      if (ended) begin
        m_act = 0;
        m_state = (m_left > 0) ? P_PLAY : P_OVER;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},      state,       m_state);
    check({tag, ".player_x"},   player_x,    m_x);
    check({tag, ".aim"},        aim,         m_aim);
    check({tag, ".shot_active"}, shot_active, m_act);
    check({tag, ".shot_x"},     shot_x,      m_sx);
    check({tag, ".shot_aim"},   shot_aim,    m_saim);
    check({tag, ".shot_y"},     shot_y,      m_sy);
    check({tag, ".fire"},       fire,        m_fire);
    check({tag, ".score"},      score,       m_score);
    check({tag, ".shots_left"}, shots_left,  m_left);
    check({tag, ".game_over"},  game_over,   (m_state == P_OVER) ? 1 : 0);
  endtask

  // Drive one cycle of inputs at the falling edge, clock it, compare after.
  task automatic step(input string tag, input logic lx, rx, la, ra, sh,
                      input logic [4:0] sel, input logic ft, h);
    logic [4:0] s;
    s = sel;
    s[1] = s1;
    left_x = lx; right_x = rx; left_aim = la; right_aim = ra; shoot_out = sh;
    select = s; frame_tick = ft; hit = h;
    model_step(lx, rx, la, ra, sh, s, ft, h);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_step(input string tag);
    step(tag, 0, 0, 0, 0, 0, 5'b00000, 0, 0);
  endtask

  task automatic new_game();
    s1 = 1'b0; idle_step("ng_low");
    s1 = 1'b1; idle_step("ng_high");
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    reset = 1'b1;

    // IDLE ignores moves; select[1] edge starts the game
    step("idle_mv", 0, 1, 0, 0, 0, 5'b10000, 0, 0);
    step("idle_mv", 0, 1, 0, 0, 0, 5'b10000, 0, 0);
    check("idle_x", player_x, 15);
    check("idle_state", state, P_IDLE);
    s1 = 1'b1; idle_step("commit");
    check("commit_state", state, P_PLAY);

    // moves and saturation
    for (int i = 0; i < 20; i++) step("right", 0, 1, 0, 0, 0, 5'b10000, 0, 0);
    check("x_sat_hi", player_x, 31);
    for (int i = 0; i < 40; i++) step("left", 1, 0, 0, 0, 0, 5'b10000, 0, 0);
    check("x_sat_lo", player_x, 0);
    step("both", 1, 1, 0, 0, 0, 5'b10000, 0, 0);
    check("x_both", player_x, 0);
    for (int i = 0; i < 3; i++) step("right3", 0, 1, 0, 0, 0, 5'b10000, 0, 0);

    // aim, then fire and aim locked in flight
    for (int i = 0; i < 5; i++) step("aim_up", 0, 0, 0, 1, 0, 5'b01000, 0, 0);
    check("aim_sat", aim, 7);
    step("fire1", 0, 0, 0, 0, 1, 5'b00000, 0, 0);
    check("fire_pulse", fire, 1);
    check("fire_sx", shot_x, 3);
    check("fire_left", shots_left, 4);
    step("lock", 0, 0, 1, 0, 0, 5'b01000, 0, 0);
    check("aim_locked", aim, 7);
    check("fire_once", fire, 0);
    check("shot_aim", shot_aim, 7);

    // miss after 12 ticks (first tick already consumed none)
    for (int i = 0; i < 12; i++) step("tick", 0, 0, 0, 0, 0, 5'b00000, 1, 0);
    check("miss_active", shot_active, 0);
    check("miss_state", state, P_PLAY);
    check("miss_score", score, 0);
    check("miss_sy", shot_y, 11);

    // hit together with the final tick
    step("fire2", 0, 0, 0, 0, 1, 5'b00000, 0, 0);
    for (int i = 0; i < 11; i++) step("tick2", 0, 0, 0, 0, 0, 5'b00000, 1, 0);
    step("hit_last", 0, 0, 0, 0, 0, 5'b00000, 1, 1);
    check("hit_score", score, 1);

    // spend remaining shots, reach OVER
    for (int i = 0; i < 3; i++) begin
      step("fire_n", 0, 0, 0, 0, 1, 5'b00000, 0, 0);
      step("hit_n", 0, 0, 0, 0, 0, 5'b00000, 0, 1);
    end
    check("over_state", state, P_OVER);
    check("over_flag", game_over, 1);
    step("over_mv", 0, 1, 0, 0, 0, 5'b10000, 0, 0);
    step("over_hit", 0, 0, 0, 0, 1, 5'b00000, 0, 1);
    new_game();
    check("ng_score", score, 0);
    check("ng_left", shots_left, 5);
    check("ng_x", player_x, 15);
    check("ng_state", state, P_PLAY);

    // randomized command stream
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) s1 = ~s1;
      step("rand",
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 7) == 0), 5'($urandom),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
    end

    // asynchronous reset in mid-flight
    new_game();
    step("pre_rst_fire", 0, 0, 0, 0, 1, 5'b00000, 0, 0);
    step("pre_rst_tick", 0, 0, 0, 0, 0, 5'b00000, 1, 0);
    check("pre_rst_flight", state, P_FLIGHT);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk);
    s1 = 1'b1;
    select = 5'b00010;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) idle_step("held_s1");
    check("held_s1_idle", state, P_IDLE);
    new_game();
    check("rearm_state", state, P_PLAY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
- Command consumer for the controls front end.
- Takes the one-cycle command pulses (left_x, right_x, left_aim, right_aim, shoot_out) and the select bus. Turns them into the player's game state: horizontal position, aim setting, projectile flight, score, shots remaining.
- Owns the game-level FSM (idle / play / flight / over) and the new-game sequencing driven by select.
- Sits between controls and the renderer/collision logic.

Parameters:
- X_W, 5, width of player_x and shot_x
- X_MIN, 0, leftmost legal position
- X_MAX, 31, rightmost legal position
- X_INIT, 15, position loaded on reset/new game
- AIM_MAX, 7, highest aim setting (aim range 0..AIM_MAX, 3-bit)
- AIM_INIT, 4, aim loaded on reset/new game
- SHOT_LEN, 12, frame ticks a projectile flies before a miss (shot_y 0..SHOT_LEN-1, 4-bit)
- SHOTS, 5, shots per game (4-bit counter)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- left_x  in  1  move-left command pulse
- right_x  in  1  move-right command pulse
- left_aim  in  1  aim-decrement command pulse
- right_aim  in  1  aim-increment command pulse
- shoot_out  in  1  fire command pulse
- select  in  5  command class from controls: [4] move, [3] aim, [2] new-game request, [1] new-game commit
- frame_tick  in  1  one-cycle frame strobe that advances the projectile
- hit  in  1  collision logic reports the projectile struck the target
- player_x  out  X_W  current position
- aim  out  3  current aim
- shot_active  out  1  projectile in flight
- shot_x  out  X_W  position latched at fire
- shot_aim  out  3  aim latched at fire
- shot_y  out  4  flight progress
- fire  out  1  one-cycle pulse on launch
- score  out  4  hits, saturating at 15
- shots_left  out  4  remaining shots
- game_over  out  1  high in OVER
- state  out  2  FSM state (IDLE=0, PLAY=1, FLIGHT=2, OVER=3)

Behaviour:
- Reset (reset low, async) state:
  - state=IDLE, player_x=X_INIT, aim=AIM_INIT
  - shot_*=0, shot_active=0, fire=0
  - score=0, shots_left=SHOTS, game_over=0
  - internal select[1] history=0
- New-game commit:
  - Detected as a rising edge of select[1], registered internally, valid in any state.
  - In the cycle after the edge: load all reset values except state=PLAY.
  - Overrides every other event in that cycle.
  - select[2] alone has no effect; it is informational.
- Moves: honoured only in PLAY or FLIGHT and only while select[4]=1.
  - left_x decrements player_x, saturating at X_MIN.
  - right_x increments player_x, saturating at X_MAX.
  - Both in the same cycle: no change.
  - Update is visible on the next cycle.
- Aim: honoured only in PLAY while select[3]=1.
  - left_aim decrements aim, saturating at 0.
  - right_aim increments aim, saturating at AIM_MAX.
  - Both together: no change.
  - Aim is locked during FLIGHT.
- IDLE: ignores all commands except the new-game commit.
- PLAY + shoot_out with shots_left>0 -> FLIGHT next cycle:
  - fire=1 for exactly that cycle.
  - shot_x<=player_x, shot_aim<=aim, shot_y<=0, shot_active<=1.
  - shots_left decrements.
  - shoot_out in PLAY with shots_left=0 cannot occur; if it does, it is ignored.
- FLIGHT:
  - shoot_out is ignored.
  - frame_tick increments shot_y.
  - hit=1 (any cycle): score increments (saturating at 15), shot_active<=0.
  - frame_tick with shot_y==SHOT_LEN-1 and no hit: miss, shot_active<=0.
  - hit and final tick in the same cycle: the hit wins.
- Leaving FLIGHT:
  - To PLAY if shots_left>0, else to OVER. This takes effect in the cycle after the hit or miss.
  - shot_x, shot_aim and shot_y hold their last values after flight ends.
- OVER: game_over=1, all commands ignored, score and position frozen until the new-game commit.
- hit outside FLIGHT is ignored.
- All outputs are registered; nothing is combinational from inputs.

Decomposition:
- Shared package holds:
  - state encodings
  - select bit indices (SEL_MOVE=4, SEL_AIM=3, SEL_NEW_REQ=2, SEL_NEW_COMMIT=1)
  - saturating-limit constants
- One sub-module, edge_rise: registered rising-edge detector with async active-low reset, used for the select[1] commit.

Test Plan:
- Release reset, pulse right_x with select=10000 twice while in IDLE -> player_x stays 15, state=0. Raise select[1] -> state=1 on the cycle after the edge, player_x=15.
- In PLAY with select=10000, apply 20 right_x pulses -> player_x saturates at 31. Apply 40 left_x pulses -> 0. A cycle with left_x and right_x both high -> unchanged.
- In PLAY with select=01000, apply 5 right_aim -> aim=7. Fire, then apply right_aim during FLIGHT -> aim stays 7, shot_aim=7, fire high one cycle, shots_left=4.
- Fire, then 12 frame_ticks with no hit -> shot_active drops after the 12th tick, score=0, state back to PLAY. Fire again and assert hit together with the 12th tick -> score=1.
- Spend all 5 shots -> state=OVER, game_over=1, moves ignored. Raise select[1] -> score=0, shots_left=5, player_x=15, state=PLAY.
- Assert reset mid-FLIGHT -> all outputs return to reset values immediately (asynchronously), state=IDLE. A select[1] already high at release does not start a game until it falls and rises again.
